// File: rtl/data_ram_resp_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_resp_pkg
//   Shared types and helpers for the MEM-stage data-memory responder.
//   - state_e       : responder FSM state codes (2 bits)
//   - WAIT_CNT_W    : width of the wait-cycle counter (supports 0..15)
//   - NUM_LANES     : number of byte lanes in a 32-bit word
//   - sel_misaligned: flags byte-lane enables that are not a legal
//                     byte/half/word access for the given byte offset
// ---------------------------------------------------------------------------
package data_ram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int NUM_LANES  = 4;

  // Legal patterns: single byte at any offset, halfword on an even offset,
  // full word on a word-aligned offset. Everything else is a bus error.
  function automatic logic sel_misaligned(input logic [3:0] sel,
                                          input logic [1:0] off);
    logic bad;
    case (sel)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: bad = 1'b0;
      4'b1100, 4'b0011:                   bad = off[0];
      4'b1111:                            bad = |off;
      default:                            bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_ram_resp_lane.sv
// ---------------------------------------------------------------------------
// data_ram_resp_lane
//   One byte lane of the data memory: 8-bit x 2**ADDR_W synchronous RAM with
//   registered read. The read register only updates on a read strobe so the
//   word presented on the bus holds until the next load.
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears the read register only)
//   we_i     in   write strobe
//   re_i     in   read strobe (loads the read register)
//   clr_i    in   with re_i: load zero instead of RAM contents
//   addr_i   in   word index
//   wdata_i  in   byte to write
//   rdata_o  out  registered read byte
// ---------------------------------------------------------------------------
module data_ram_resp_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [0:(2**ADDR_W)-1];
  logic [7:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else if (re_i) begin
      rdata_q <= clr_i ? 8'h00 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// ---------------------------------------------------------------------------
// data_ram_resp
//   Data-memory responder for the MEM stage. Serves one load/store at a time,
//   with WAIT_CYCLES (0..15) extra cycles before the one-cycle ack. Byte lanes
//   are big-endian: sel[3] / data[31:24] is byte address 00.
// Parameters
//   ADDR_W       word-address bits (DEPTH = 2**ADDR_W words), at most 29
//   WAIT_CYCLES  extra wait cycles before the response
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   ce         in   request valid, held until ack
//   we         in   1 = store, 0 = load
//   addr       in   byte address; word index = addr[ADDR_W+1:2]
//   sel        in   byte-lane enables
//   data_i     in   lane-aligned store data
//   data_o     out  full load word, held until the next load completes
//   ack        out  one-cycle completion pulse
//   stall_req  out  ce & ~ack (combinational)
//   err        out  bus error, valid with ack
// Build option
//   DATA_RAM_BUSERR_EN : enables lane/alignment/range checking on err.
//                        Undefined: err is 0 and high address bits wrap.
// ---------------------------------------------------------------------------
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack,
  output logic        stall_req,
  output logic        err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                  state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [3:0]              sel_q;
  logic [31:0]             data_q;

  logic                    in_idle;
  logic                    exec;
  logic                    req_we;
  logic [31:0]             req_addr;
  logic [3:0]              req_sel;
  logic [31:0]             req_data;
  logic                    req_err;

  assign in_idle = (state_q == ST_IDLE);

  // With zero wait the access happens on the accepting edge, so it must use
  // the live bus; otherwise it uses the copy latched at acceptance.
  assign req_we   = in_idle ? we     : we_q;
  assign req_addr = in_idle ? addr   : addr_q;
  assign req_sel  = in_idle ? sel    : sel_q;
  assign req_data = in_idle ? data_i : data_q;

  // The access fires on the edge that moves the FSM into RESP.
  assign exec = (in_idle && ce && (WAIT_CYCLES == 0)) ||
                ((state_q == ST_WAIT) && (cnt_q == '0));

`ifdef DATA_RAM_BUSERR_EN
  assign req_err = sel_misaligned(req_sel, req_addr[1:0]) |
                   (|req_addr[31:ADDR_W+2]);
  assign err     = err_q;
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0], err_q};
  assign req_err     = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= exec;
      err_q <= exec & req_err;
      case (state_q)
        ST_IDLE: begin
          if (ce) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // ce is deliberately ignored here: a new request needs an IDLE cycle.
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request capture needs no reset: it is only consumed after acceptance.
  always_ff @(posedge clk) begin
    if (in_idle && ce) begin
      we_q   <= we;
      addr_q <= addr;
      sel_q  <= sel;
      data_q <= data_i;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    data_ram_resp_lane #(
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we_i    (exec & ~rst & req_we & req_sel[gi] & ~req_err),
      .re_i    (exec & ~rst & ~req_we),
      .clr_i   (req_err),
      .addr_i  (req_addr[ADDR_W+1:2]),
      .wdata_i (req_data[8*gi +: 8]),
      .rdata_o (data_o[8*gi +: 8])
    );
  end

  assign ack       = ack_q;
  assign stall_req = ce & ~ack_q;

endmodule
